alu_sequencer: RTL and testbench

Execute-stage controller that drives the combinational 16-bit ALU from the other side of its opcode/operand/result/flags interface. It accepts one instruction at a time over a valid/ready handshake, reads operands from an internal 8x16 register file, issues registered opcode and operands to the ALU, and samples the ALU result and flags. It then writes back to the register file and a 4-bit flags register, with optional flag-conditional execution.

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Execute-stage controller for a combinational 16-bit ALU. Accepts one
//   instruction at a time over valid/ready, reads operands from an internal
//   8x16 register file, presents registered opcode/operands to the ALU,
//   captures the result/flags, then writes back to the register file and the
//   4-bit flags register. Supports flag-conditional execution.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      instruction handshake (ready only in IDLE, not in reset)
//   in_opcode                ALU opcode 0x01..0x11, or 0x80 = LOADI
//   in_rd, in_rs1, in_rs2    destination / source register indices
//   in_imm                   LOADI immediate
//   in_cond_en, in_cond_sel  conditional execution enable, flag select
//   alu_opcode, alu_a, alu_b registered ALU request
//   alu_result, alu_flags    ALU response (flags[3:0] = ovf, zero, neg, carry)
//   flags                    architectural flags {ovf, zero, neg, carry}
//   done, skipped, err       retire pulse and its qualifiers
//   dbg_addr, dbg_data       combinational register-file read port
module alu_sequencer #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_opcode,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rs1,
  input  logic [2:0]       in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_cond_en,
  input  logic [1:0]       in_cond_sel,
  output logic [7:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [15:0]      alu_flags,
  output logic [3:0]       flags,
  output logic             done,
  output logic             skipped,
  output logic             err,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [7:0] OP_LOADI = 8'h80;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [3:0]       flags_q, flags_d;

  // Instruction fields latched at accept
  logic [7:0]       op_q;
  logic [2:0]       rd_q;
  logic [WIDTH-1:0] imm_q;
  logic             cond_ok_q;

  // ALU response captured at the end of EXEC
  logic [WIDTH-1:0] res_q;
  logic [3:0]       aflags_q;

  logic             accept;
  logic             cond_ok;
  logic             legal;
  logic             is_loadi;
  logic             is_addsub;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  // Only the low four ALU flag bits carry meaning here.
  logic             unused_alu_flags;
  assign unused_alu_flags = ^alu_flags[15:4];

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign cond_ok  = !in_cond_en || flags_q[in_cond_sel];
  assign flags    = flags_q;
  assign dbg_data = regs_q[dbg_addr];

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      regs_q     <= '{default: '0};
      flags_q    <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      cond_ok_q  <= 1'b0;
      res_q      <= '0;
      aflags_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (accept) begin
        op_q       <= in_opcode;
        rd_q       <= in_rd;
        imm_q      <= in_imm;
        cond_ok_q  <= cond_ok;
        alu_opcode <= in_opcode;
        alu_a      <= regs_q[in_rs1];
        alu_b      <= regs_q[in_rs2];
      end
      if (state_q == EXEC) begin
        res_q    <= alu_result;
        aflags_q <= alu_flags[3:0];
      end
      if (wr_en) begin
        regs_q[rd_q] <= wr_data;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback decode: register write and flags update applied at the WB edge
  always_comb begin
    is_loadi  = (op_q == OP_LOADI);
    is_addsub = (op_q == 8'h01) || (op_q == 8'h02);
    legal     = is_loadi || ((op_q >= 8'h01) && (op_q <= 8'h11));
    wr_en     = (state_q == WB) && cond_ok_q && legal;
    wr_data   = is_loadi ? imm_q : res_q;
    flags_d   = flags_q;
    if (wr_en && !is_loadi) begin
      if (is_addsub) begin
        flags_d = aflags_q;
      end else begin
        // Logic/shift ops: carry preserved, overflow cleared, sign from result
        flags_d = {1'b0, aflags_q[2], res_q[WIDTH-1], flags_q[0]};
      end
    end
  end

  // Outputs
  always_comb begin
    done    = (state_q == WB);
    skipped = done && !cond_ok_q;
    err     = done && cond_ok_q && !legal;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_opcode = '0;
  logic [2:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [15:0] in_imm = '0;
  logic        in_cond_en = 1'b0;
  logic [1:0]  in_cond_sel = '0;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result, alu_flags;
  logic [3:0]  flags;
  logic        done, skipped, err;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        skp;
    logic        er;
    logic [2:0]  rd;
    logic [15:0] rdval;
    logic [3:0]  fl;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;
  int          accept_cnt = 0;
  time         acc_times[$];

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(8), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_cond_en(in_cond_en), .in_cond_sel(in_cond_sel),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags), .flags(flags),
    .done(done), .skipped(skipped), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in ALU: returns {flags16, result}. For non add/sub ops the negative
  // and overflow bits are deliberately wrong so the sequencer's own flag
  // derivation is observable.
  function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, n, v;
    s = '0;
    case (op)
      8'h01: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16]; n = r[15];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      8'h02: begin
        r = a - b; c = (a < b); n = r[15];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: begin
        case (op)
          8'h03:   r = a & b;
          8'h04:   r = a | b;
          8'h05:   r = a ^ b;
          default: r = a ^ {b[7:0], b[15:8]} ^ {8'h00, op};
        endcase
        c = 1'b0; n = ~r[15]; v = 1'b1;
      end
    endcase
    return {12'hA5C, v, (r == 16'h0000), n, c, r};
  endfunction

  logic [31:0] alu_out;
  assign alu_out    = alu_model(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_out[15:0];
  assign alu_flags  = alu_out[31:16];

  // Accept counter (pre-edge values of the handshake)
  always @(posedge clk) begin
    if (!rst && in_valid === 1'b1 && in_ready === 1'b1) begin
      accept_cnt++;
      acc_times.push_back($time);
    end
  end

  // Scoreboard monitor: pops on every retire
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 skipped=%b err=%b with nothing outstanding", skipped, err);
      end else begin
        mon_e = exp_q.pop_front();
        if (skipped !== mon_e.skp || err !== mon_e.er) begin
          errors++;
          $display("FAIL retire_qualifiers: skipped=%b err=%b, required skipped=%b err=%b", skipped, err, mon_e.skp, mon_e.er);
        end
        dbg_addr = mon_e.rd;
        @(negedge clk);
        checks++;
        if (dbg_data !== mon_e.rdval) begin
          errors++;
          $display("FAIL writeback r%0d: got %h, required %h", mon_e.rd, dbg_data, mon_e.rdval);
        end
        checks++;
        if (flags !== mon_e.fl) begin
          errors++;
          $display("FAIL flags_after_commit: got %b, required %b", flags, mon_e.fl);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm, input logic ce,
                       input logic [1:0] cs, input bit hold);
    int unsigned w = 0;
    exp_t        e;
    logic [31:0] ar;
    logic        ok, legal;
    logic [15:0] a, b;
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_cond_en = ce; in_cond_sel = cs; in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
      in_valid = 1'b0;
      return;
    end
    a     = m_regs[rs1];
    b     = m_regs[rs2];
    ok    = !ce || m_flags[cs];
    legal = (op == 8'h80) || (op >= 8'h01 && op <= 8'h11);
    ar    = alu_model(op, a, b);
    if (ok && legal) begin
      if (op == 8'h80) begin
        m_regs[rd] = imm;
      end else begin
        m_regs[rd] = ar[15:0];
        if (op <= 8'h02) m_flags = ar[19:16];
        else             m_flags = {1'b0, ar[18], ar[15], m_flags[0]};
      end
    end
    e.skp = !ok; e.er = ok && !legal; e.rd = rd; e.rdval = m_regs[rd]; e.fl = m_flags;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    checks++;
    if ({alu_opcode, alu_a, alu_b} !== {op, a, b}) begin
      errors++;
      $display("FAIL issue_operands: op=%h a=%h b=%h, required op=%h a=%h b=%h", alu_opcode, alu_a, alu_b, op, a, b);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL exec_phase: done=%b in_ready=%b, required 0 0", done, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wb_phase: done=%b in_ready=%b, required 1 0", done, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || {alu_opcode, alu_a, alu_b} !== {op, a, b}) begin
      errors++;
      $display("FAIL idle_after_wb: done=%b in_ready=%b op=%h a=%h b=%h, required 0 1 %h %h %h",
               done, in_ready, alu_opcode, alu_a, alu_b, op, a, b);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_regs  = '{default: 16'h0000};
    m_flags = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0 || skipped !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b done=%b skipped=%b err=%b, required all 0", in_ready, done, skipped, err);
    end
    checks++;
    if (alu_opcode !== 8'h00 || alu_a !== 16'h0000 || alu_b !== 16'h0000 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_data: op=%h a=%h b=%h flags=%b, required 0", alu_opcode, alu_a, alu_b, flags);
    end
    dbg_addr = 3'd5;
    #1;
    checks++;
    if (dbg_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: r5=%h, required 0000", dbg_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_add_overflow;
    issue(8'h80, 3'd1, 3'd0, 3'd0, 16'h7FFF, 1'b0, 2'd0, 1'b0);
    issue(8'h80, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0, 2'd0, 1'b0);
    issue(8'h01, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, 2'd0, 1'b0);
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data !== 16'h8000 || flags !== 4'b1010) begin
      errors++;
      $display("FAIL add_overflow: r3=%h flags=%b, required 8000 1010", dbg_data, flags);
    end
  endtask

  task automatic test_sub_zero_neg;
    issue(8'h02, 3'd4, 3'd0, 3'd0, 16'h0000, 1'b0, 2'd0, 1'b0);
    dbg_addr = 3'd4;
    #1;
    checks++;
    if (dbg_data !== 16'h0000 || flags[2] !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: r4=%h zero=%b, required 0000 1", dbg_data, flags[2]);
    end
    issue(8'h80, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b0, 2'd0, 1'b0);
    issue(8'h80, 3'd2, 3'd0, 3'd0, 16'h0007, 1'b0, 2'd0, 1'b0);
    issue(8'h02, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b0, 2'd0, 1'b0);
    dbg_addr = 3'd5;
    #1;
    checks++;
    if (dbg_data !== 16'hFFFE || flags[1] !== 1'b1) begin
      errors++;
      $display("FAIL sub_negative: r5=%h neg=%b, required FFFE 1", dbg_data, flags[1]);
    end
  endtask

  task automatic test_logic_flags;
    issue(8'h80, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b0, 2'd0, 1'b0);
    issue(8'h80, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0, 2'd0, 1'b0);
    issue(8'h01, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, 2'd0, 1'b0);
    issue(8'h80, 3'd2, 3'd0, 3'd0, 16'h0000, 1'b0, 2'd0, 1'b0);
    issue(8'h03, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, 2'd0, 1'b0);
    checks++;
    if (flags !== 4'b0101) begin
      errors++;
      $display("FAIL and_flags: flags=%b, required 0101", flags);
    end
    issue(8'h80, 3'd7, 3'd0, 3'd0, 16'h1234, 1'b1, 2'd2, 1'b0);
    dbg_addr = 3'd7;
    #1;
    checks++;
    if (dbg_data !== 16'h1234) begin
      errors++;
      $display("FAIL cond_loadi: r7=%h, required 1234", dbg_data);
    end
    issue(8'h04, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, 2'd0, 1'b0);
    checks++;
    if (flags !== 4'b0011) begin
      errors++;
      $display("FAIL or_flags: flags=%b, required 0011", flags);
    end
  endtask

  task automatic test_cond_and_illegal;
    logic [7:0] ops [9] = '{8'h01, 8'h55, 8'h55, 8'h00, 8'h12, 8'h7F, 8'h81, 8'h11, 8'h80};
    logic [2:0] rds [9] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd0};
    logic       ces [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] css [9] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    for (int k = 0; k < 9; k++) begin
      issue(ops[k], rds[k], 3'd1, 3'd2, 16'hBEEF, ces[k], css[k], 1'b0);
    end
    dbg_addr = 3'd1;
    #1;
    checks++;
    if (dbg_data !== 16'hFFFF || flags !== 4'b0011) begin
      errors++;
      $display("FAIL no_write_on_skip_err: r1=%h flags=%b, required FFFF 0011", dbg_data, flags);
    end
  endtask

  task automatic test_reset_mid;
    int unsigned w = 0;
    in_opcode = 8'h01; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
    in_cond_en = 1'b0; in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_regs  = '{default: 16'h0000};
    m_flags = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL in_reset: in_ready=%b done=%b, required 0 0", in_ready, done);
      end
    end
    rst = 1'b0;
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (in_ready !== 1'b1 || flags !== 4'b0000 || dbg_data !== 16'h0000 || alu_opcode !== 8'h00) begin
      errors++;
      $display("FAIL after_mid_reset: in_ready=%b flags=%b r3=%h op=%h, required 1 0000 0000 00",
               in_ready, flags, dbg_data, alu_opcode);
    end
  endtask

  task automatic test_back_to_back;
    int  c0;
    int  t0;
    c0 = accept_cnt;
    t0 = acc_times.size();
    issue(8'h80, 3'd1, 3'd0, 3'd0, 16'h0003, 1'b0, 2'd0, 1'b1);
    issue(8'h01, 3'd2, 3'd1, 3'd1, 16'h0000, 1'b0, 2'd0, 1'b1);
    issue(8'h01, 3'd3, 3'd2, 3'd1, 16'h0000, 1'b0, 2'd0, 1'b1);
    issue(8'h05, 3'd4, 3'd3, 3'd2, 16'h0000, 1'b0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (accept_cnt - c0 != 4) begin
      errors++;
      $display("FAIL accept_count: got %0d, required 4", accept_cnt - c0);
    end
    for (int k = t0 + 1; k < acc_times.size(); k++) begin
      checks++;
      if (acc_times[k] - acc_times[k-1] != 30) begin
        errors++;
        $display("FAIL accept_spacing: got %0t, required 30", acc_times[k] - acc_times[k-1]);
      end
    end
    dbg_addr = 3'd4;
    #1;
    checks++;
    if (dbg_data !== 16'h000F) begin
      errors++;
      $display("FAIL dependent_chain: r4=%h, required 000F", dbg_data);
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_zero_neg;
    test_logic_flags;
    test_cond_and_illegal;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_retires: %0d never retired, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
